// File: rtl/fix_lut_sequencer.sv
// Time-multiplexed cumulative LUT accumulator: walks one control-bit vector in
// slices of step_bits, summing +/-fact[j] into a shared accumulator per slice.
module fix_lut_sequencer #(
  parameter int size      = 1,
  parameter int step_bits = 6,
  parameter int n_int     = 8,
  parameter int n_mant    = 23,
  parameter logic signed [size-1:0][n_int+n_mant:0] fact = '0
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [size-1:0]                 sel,
  output logic                            out_valid,
  output logic signed [n_int+n_mant:0]    result,
  output logic                            busy,
  output logic                            overrun
);

  localparam int W      = n_int + n_mant + 1;
  localparam int STEPS  = (size + step_bits - 1) / step_bits;
  localparam int STEP_W = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam logic [STEP_W-1:0] LAST = STEP_W'(STEPS - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t                state_q, state_d;
  logic [size-1:0]       sel_q;
  logic [STEP_W-1:0]     step_q;
  logic signed [W-1:0]   acc_q;
  logic signed [W-1:0]   chain [size+1];
  logic signed [W-1:0]   part;

  // Each bit contributes only when the step counter addresses its slice.
  assign chain[0] = '0;
  for (genvar g = 0; g < size; g++) begin : g_slice
    logic signed [W-1:0] coef;
    logic signed [W-1:0] contrib;
    assign coef    = fact[g];
    assign contrib = sel_q[g] ? coef : (W'(0) - coef);
    assign chain[g+1] = chain[g] +
                        ((step_q == STEP_W'(g / step_bits)) ? contrib : W'(0));
  end
  assign part = chain[size];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid)       state_d = RUN;
      RUN:     if (step_q == LAST) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready = (state_q == IDLE);
    busy     = (state_q == RUN);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel_q     <= '0;
      step_q    <= '0;
      acc_q     <= '0;
      result    <= '0;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      // A sample offered while busy is dropped; the flag stays until reset.
      if (in_valid && !in_ready) overrun <= 1'b1;
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            sel_q  <= sel;
            step_q <= '0;
            acc_q  <= '0;
          end
        end
        RUN: begin
          if (step_q == LAST) begin
            result    <= acc_q + part;
            out_valid <= 1'b1;
            acc_q     <= '0;
            step_q    <= '0;
          end else begin
            acc_q  <= acc_q + part;
            step_q <= step_q + STEP_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fix_lut_sequencer.sv
// Bench for fix_lut_sequencer: 4-bit/2-step main config plus a 5-bit/3-step
// remainder-and-wrap config, results checked against a scoreboard queue.
module tb_fix_lut_sequencer;

  localparam logic signed [3:0][7:0] FACT_M = {8'sd8, 8'sd4, 8'sd2, 8'sd1};
  localparam logic signed [4:0][7:0] FACT_R = {5{8'sd60}};

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [3:0]        sel = '0;
  logic              out_valid;
  logic signed [7:0] result;
  logic              busy;
  logic              overrun;

  logic              in_valid_r = 1'b0;
  logic              in_ready_r;
  logic [4:0]        sel_r = '0;
  logic              out_valid_r;
  logic signed [7:0] result_r;
  logic              busy_r;
  logic              overrun_r;

  int checks = 0;
  int errors = 0;
  logic signed [7:0] q_main [$];
  logic signed [7:0] q_rem  [$];

  always #5 clk = ~clk;

  fix_lut_sequencer #(
    .size(4), .step_bits(2), .n_int(3), .n_mant(4), .fact(FACT_M)
  ) u_main (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .sel(sel),
    .out_valid(out_valid), .result(result), .busy(busy), .overrun(overrun)
  );

  fix_lut_sequencer #(
    .size(5), .step_bits(2), .n_int(3), .n_mant(4), .fact(FACT_R)
  ) u_rem (
    .clk(clk), .rst(rst), .in_valid(in_valid_r), .in_ready(in_ready_r), .sel(sel_r),
    .out_valid(out_valid_r), .result(result_r), .busy(busy_r), .overrun(overrun_r)
  );

  // Scoreboard monitor for the main instance.
  always @(negedge clk) begin
    if (out_valid === 1'b1) begin
      checks++;
      if (q_main.size() == 0) begin
        errors++;
        $display("FAIL unexpected_out_valid: got result %0d with nothing expected", result);
      end else begin
        logic signed [7:0] exp;
        exp = q_main.pop_front();
        if (result !== exp) begin
          errors++;
          $display("FAIL result: got %0d (%h) want %0d (%h)", result, result, exp, exp);
        end
      end
    end
  end

  task automatic test_reset();
    repeat (5) @(posedge clk);
    @(negedge clk);
    checks++; if (result !== 8'sd0)  begin errors++; $display("FAIL reset_result: got %h want 00", result); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    checks++; if (in_ready !== 1'b1)  begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (overrun !== 1'b0)   begin errors++; $display("FAIL reset_overrun: got %b want 0", overrun); end
  endtask

  task automatic test_single(input logic [3:0] s, input logic signed [7:0] exp, input string name);
    @(posedge clk); #1 sel = s; in_valid = 1'b1;
    @(posedge clk); q_main.push_back(exp); #1 in_valid = 1'b0; sel = ~s;
    @(negedge clk);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL %s busy_e0: got %b want 1", name, busy); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL %s in_ready_e0: got %b want 0", name, in_ready); end
    @(posedge clk); @(negedge clk);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL %s busy_e1: got %b want 1", name, busy); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL %s out_valid_e1: got %b want 0", name, out_valid); end
    @(posedge clk); @(negedge clk);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL %s out_valid_e2: got %b want 1", name, out_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL %s busy_e2: got %b want 0", name, busy); end
    @(posedge clk); @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL %s out_valid_e3: got %b want 0", name, out_valid); end
    checks++; if (result !== exp) begin errors++; $display("FAIL %s result_hold: got %0d want %0d", name, result, exp); end
  endtask

  task automatic test_back_to_back();
    @(posedge clk); #1 sel = 4'b1111; in_valid = 1'b1;
    @(posedge clk); q_main.push_back(8'sd15); #1 sel = 4'b0101;
    @(negedge clk);
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL b2b_overrun_e0: got %b want 0", overrun); end
    @(posedge clk); @(negedge clk);
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL b2b_overrun_e1: got %b want 1", overrun); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_out_valid_e1: got %b want 0", out_valid); end
    @(posedge clk); #1 sel = 4'b0000;
    @(negedge clk);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL b2b_out_valid_e2: got %b want 1", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_in_ready_e2: got %b want 1", in_ready); end
    @(posedge clk); q_main.push_back(-8'sd15); #1 in_valid = 1'b0;
    @(negedge clk);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_busy_e3: got %b want 1", busy); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_out_valid_e3: got %b want 0", out_valid); end
    @(posedge clk); @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_out_valid_e4: got %b want 0", out_valid); end
    @(posedge clk); @(negedge clk);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL b2b_out_valid_e5: got %b want 1", out_valid); end
    @(posedge clk); @(negedge clk);
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL b2b_overrun_sticky: got %b want 1", overrun); end
  endtask

  task automatic test_reset_mid_run();
    @(posedge clk); #1 sel = 4'b1111; in_valid = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    checks++; if (result !== 8'sd0) begin errors++; $display("FAIL midrst_result: got %h want 00", result); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL midrst_in_ready: got %b want 1", in_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b want 0", busy); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL midrst_overrun: got %b want 0", overrun); end
    @(posedge clk); #1 rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_no_out_valid: got %b want 0 at cycle %0d", out_valid, c); end
    end
    test_single(4'b0101, -8'sd5, "after_rst_0101");
  endtask

  task automatic test_remainder_wrap();
    logic [4:0]        pats [3];
    logic signed [7:0] exps [3];
    pats = '{5'b11111, 5'b00000, 5'b10101};
    exps = '{8'sh2C, 8'shD4, 8'sh3C};
    for (int p = 0; p < 3; p++) begin
      @(posedge clk); #1 sel_r = pats[p]; in_valid_r = 1'b1;
      @(posedge clk); q_rem.push_back(exps[p]); #1 in_valid_r = 1'b0; sel_r = ~pats[p];
      for (int c = 1; c <= 3; c++) begin
        @(posedge clk); @(negedge clk);
        if (c < 3) begin
          checks++; if (out_valid_r !== 1'b0 || busy_r !== 1'b1) begin
            errors++; $display("FAIL rem_timing: pat %b cycle %0d got out_valid %b busy %b want 0 1", pats[p], c, out_valid_r, busy_r);
          end
        end else begin
          logic signed [7:0] exp;
          exp = q_rem.pop_front();
          checks++; if (out_valid_r !== 1'b1) begin errors++; $display("FAIL rem_out_valid: pat %b got %b want 1", pats[p], out_valid_r); end
          checks++; if (result_r !== exp) begin errors++; $display("FAIL rem_result: pat %b got %h want %h", pats[p], result_r, exp); end
        end
      end
    end
    checks++; if (overrun_r !== 1'b0) begin errors++; $display("FAIL rem_overrun: got %b want 0", overrun_r); end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    test_reset();
    test_single(4'b1111,  8'sd15, "sel_1111");
    test_single(4'b0000, -8'sd15, "sel_0000");
    test_single(4'b0101, -8'sd5,  "sel_0101");
    test_back_to_back();
    test_reset_mid_run();
    test_remainder_wrap();
    repeat (2) @(negedge clk);
    checks++;
    if (q_main.size() != 0) begin
      errors++; $display("FAIL scoreboard_drain: got %0d pending want 0", q_main.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fix_lut_sequencer.md
Name: fix_lut_sequencer

Overview:
- Time-multiplexed replacement for the clock-gated cumulative LUT accumulator in the fixed-point digital estimation filter.
- Accepts one control-bit vector per sample through a valid/ready handshake.
- Steps through the vector in slices of `step_bits`, adding each slice's ±fact partial sum into one shared accumulator, then emits the result with a one-cycle `out_valid` pulse.
- Fully synchronous: no derived clocks, no edge-detect resets.

Parameters:
- `size`, 1: number of control bits / coefficients.
- `step_bits`, 6: bits consumed per accumulation step.
- `n_int`, 8: integer bits; word width `W` = `n_int+n_mant+1`, signed two's complement.
- `n_mant`, 23: fractional bits.
- `fact`, 0: signed packed array [size-1:0][W-1:0]; coefficient per control bit.
- Derived: `STEPS` = ceil(size/step_bits); step counter width = max(1, clog2(STEPS)).

Ports:
- `clk`  in  1  clock, all state on posedge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  `sel` holds a new sample.
- `in_ready`  out  1  block can accept a sample.
- `sel`  in  size  control bits; bit j selects +fact[j] (1) or −fact[j] (0).
- `out_valid`  out  1  one-cycle pulse; `result` updated.
- `result`  out  W  signed accumulated estimate; held between pulses.
- `busy`  out  1  accumulation in progress.
- `overrun`  out  1  sticky: `in_valid` seen while `in_ready` was low.

Behaviour:
- Reset (async, any state, mid-run included):
  - state=IDLE; step=0; acc=0; `sel_q`=0.
  - `result`=0, `out_valid`=0, `overrun`=0.
  - In-flight sample discarded; no `out_valid` follows.
- States: IDLE, RUN.
- `in_ready` = (state==IDLE); `busy` = (state==RUN); both combinational from state.
- IDLE:
  - On edge with `in_valid`&&`in_ready`: `sel_q`<=`sel`, step<=0, acc<=0, state<=RUN.
  - Otherwise hold.
- RUN, each edge:
  - p = sum over j in [step*step_bits, min((step+1)*step_bits, size)) of (`sel_q`[j] ? +fact[j] : −fact[j]).
  - Last slice may be shorter than `step_bits` (size % step_bits bits).
  - If step < STEPS−1: acc<=acc+p; step<=step+1.
  - If step == STEPS−1: `result`<=acc+p; `out_valid`<=1; acc<=0; step<=0; state<=IDLE.
- `out_valid` is registered; it deasserts on the next edge unless another completion occurs.
- Latency: accept edge E0 → `result`/`out_valid` valid after edge E0+STEPS.
  - Throughput: one sample per STEPS+1 cycles.
  - A new sample is accepted in the same cycle `out_valid` is high, since state is IDLE.
- STEPS==1: a single RUN cycle; latency 1.
- Arithmetic:
  - All sums W bits, two's complement, wrap on overflow, no saturation.
  - `fact` is used at full W width; no sign extension beyond W.
- `sel` is sampled only on the accept edge; changes during RUN are ignored.
- `overrun`:
  - Set on any edge with `in_valid`=1 and `in_ready`=0; that sample is dropped.
  - Cleared only by `rst`.
  - Simultaneous completion and `in_valid`: state is still RUN on that edge, so `overrun` sets.
- `in_valid` while IDLE with no prior activity: accepted normally; `overrun` is not set.

Test Plan:
- Common bench config: size=4, step_bits=2, n_int=3, n_mant=4 (W=8), fact={8,4,2,1} (index 3..0), STEPS=2.
- Reset then idle 5 cycles → `result`=0, `out_valid`=0, `in_ready`=1, `busy`=0, `overrun`=0.
- `sel`=4'b1111 accepted at E0 → `busy`=1 for 2 cycles; `out_valid`=1 after E2 with `result`=15 (8'h0F); `out_valid`=0 after E3.
- `sel`=4'b0000 → `result`=−15 (8'hF1); `sel`=4'b0101 → `result`=+1−2+4−8 = −5 (8'hFB).
- Back-to-back:
  - `in_valid` held high with 1111 then 0000, accepted at E0 and E3.
  - `out_valid` after E2 (15) and E5 (−15).
  - `in_valid` pulsed at E1 sets `overrun`=1, and that sample never appears.
- Reset mid-run: assert `rst` asynchronously between E0 and E1 of a 1111 sample → `result`=0 immediately, no `out_valid`, `in_ready`=1; next 0101 sample gives −5.
- Remainder/wrap config: size=5, step_bits=2 (STEPS=3), W=8, fact all 8'd60, `sel`=5'b11111 → `result`=300 mod 256 = 44 (8'h2C), after 3 cycles.
